// File: rtl/fir2p_feeder.sv
// Sample/coefficient feeder for the 2-parallel FIR: pairs a sample stream, sequences coefficient loads.
// Optional FEED_PAD_EN adds s_last so a tagged lone sample is flushed as {sample, 0}.
module fir2p_feeder #(
  parameter int DW        = 8,
  parameter int NCOEF     = 10,
  parameter int CW        = 4,
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
`ifdef FEED_PAD_EN
  input  logic          s_last,
`endif
  input  logic          c_start,
  input  logic [DW-1:0] c_data,
  input  logic          c_valid,
  output logic          c_ready,
  output logic [DW-1:0] in0,
  output logic [DW-1:0] in1,
  output logic          pair_valid,
  output logic [CW-1:0] Coef_num,
  output logic [DW-1:0] Coef_Val,
  output logic          Coef_w_en,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam int FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

  state_t        state, state_n;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [NW-1:0] count;
  logic          push;
  logic [1:0]    pop_n;
  logic          pad;
  logic [CW-1:0] idx;
  logic [FW-1:0] fcnt;
  logic          c_fire;
  logic          last_coef;

  assign s_ready   = count < NW'(DEPTH);
  assign push      = s_valid && s_ready;
  assign rd_nxt    = rd_ptr + PW'(1);
  assign c_ready   = (state == LOAD);
  assign busy      = (state != RUN);
  assign c_fire    = c_ready && c_valid;
  assign last_coef = (idx == CW'(NCOEF - 1));

`ifdef FEED_PAD_EN
  logic [DEPTH-1:0] tag;

  assign pad = (count == NW'(1)) && tag[rd_ptr];

  // Tags clear on pop so a tagged sample that pairs normally leaves no stale pad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag <= '0;
    end else begin
      if (pop_n != 2'd0) tag[rd_ptr] <= 1'b0;
      if (pop_n == 2'd2) tag[rd_nxt] <= 1'b0;
      if (push)          tag[wr_ptr] <= s_last;
    end
  end
`else
  assign pad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pop_n   = 2'd0;
    unique case (state)
      RUN: begin
        if (count >= NW'(2)) pop_n = 2'd2;
        else if (pad)        pop_n = 2'd1;
        if (c_start) state_n = LOAD;
      end
      LOAD: begin
        if (c_fire && last_coef) state_n = FLUSH;
      end
      FLUSH: begin
        if (fcnt == FW'(1)) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      fcnt       <= '0;
      in0        <= '0;
      in1        <= '0;
      pair_valid <= 1'b0;
      Coef_w_en  <= 1'b0;
      Coef_num   <= '0;
      Coef_Val   <= '0;
    end else begin
      count  <= count + NW'(push) - NW'(pop_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      if (push) wr_ptr <= wr_ptr + PW'(1);

      in0        <= '0;
      in1        <= '0;
      pair_valid <= 1'b0;
      if (pop_n != 2'd0) begin
        in0        <= mem[rd_ptr];
        in1        <= (pop_n == 2'd2) ? mem[rd_nxt] : '0;
        pair_valid <= 1'b1;
      end

      Coef_w_en <= 1'b0;
      Coef_num  <= '0;
      Coef_Val  <= '0;
      if (c_fire) begin
        Coef_w_en <= 1'b1;
        Coef_num  <= idx;
        Coef_Val  <= c_data;
        idx       <= idx + CW'(1);
      end
      if (state == RUN && c_start) idx <= '0;

      if (c_fire && last_coef) fcnt <= FW'(FLUSH_CYC);
      else if (state == FLUSH) fcnt <= fcnt - FW'(1);
    end
  end

endmodule

// File: tb/tb_fir2p_feeder.sv
// Scoreboard bench for fir2p_feeder: stimulus queues expected pairs/writes, a monitor checks them.
// Build with +define+FEED_PAD_EN to exercise the lone-sample pad path.
module tb_fir2p_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
`ifdef FEED_PAD_EN
  logic       s_last;
`endif
  logic       c_start;
  logic [7:0] c_data;
  logic       c_valid;
  logic       c_ready;
  logic [7:0] in0, in1;
  logic       pair_valid;
  logic [3:0] Coef_num;
  logic [7:0] Coef_Val;
  logic       Coef_w_en;
  logic       busy;

  fir2p_feeder dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
`ifdef FEED_PAD_EN
    .s_last(s_last),
`endif
    .c_start(c_start), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .in0(in0), .in1(in1), .pair_valid(pair_valid),
    .Coef_num(Coef_num), .Coef_Val(Coef_Val), .Coef_w_en(Coef_w_en),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         cyc;
  } pair_t;

  typedef struct {
    logic [3:0] num;
    logic [7:0] val;
    int         cyc;
  } coef_t;

  pair_t pq[$];
  coef_t cq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    pair_t p;
    coef_t c;
    checks++;
    if (pair_valid) begin
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pair_unexpected: got (%0d,%0d) expected none (cycle %0d)", in0, in1, cyc);
      end else begin
        p = pq.pop_front();
        if (in0 !== p.a || in1 !== p.b || (p.cyc >= 0 && cyc != p.cyc)) begin
          errors++;
          $display("FAIL pair: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d",
                   in0, in1, cyc, p.a, p.b, p.cyc);
        end
      end
    end else if (in0 !== 8'd0 || in1 !== 8'd0) begin
      errors++;
      $display("FAIL pair_idle: got (%0d,%0d) expected (0,0) (cycle %0d)", in0, in1, cyc);
    end
    checks++;
    if (Coef_w_en) begin
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL coef_unexpected: got #%0d=%0d expected none (cycle %0d)",
                 Coef_num, Coef_Val, cyc);
      end else begin
        c = cq.pop_front();
        if (Coef_num !== c.num || Coef_Val !== c.val || cyc != c.cyc) begin
          errors++;
          $display("FAIL coef: got #%0d=%0d@%0d expected #%0d=%0d@%0d",
                   Coef_num, Coef_Val, cyc, c.num, c.val, c.cyc);
        end
      end
    end else if (Coef_num !== 4'd0 || Coef_Val !== 8'd0) begin
      errors++;
      $display("FAIL coef_idle: got #%0d=%0d expected 0,0 (cycle %0d)", Coef_num, Coef_Val, cyc);
    end
  end

  task automatic push(input logic [7:0] v, output int acc);
    bit ok;
    ok = 1'b0;
    s_data  = v;
    s_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: got no s_ready expected accept of %0d", v);
    end
    acc = cyc;
  endtask

  task automatic coef(input int i, input int v);
    c_data  = 8'(v);
    c_valid = 1'b1;
    @(negedge clk);
    chk("c_ready_load", c_ready, 1);
    @(posedge clk);
    #1;
    cq.push_back('{4'(i), 8'(v), cyc});
  endtask

  task automatic start_load();
    c_start = 1'b1;
    @(posedge clk);
    #1;
    c_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("busy_clear", busy, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in0"}, in0, 0);
    chk({tag, "_in1"}, in1, 0);
    chk({tag, "_pair_valid"}, pair_valid, 0);
    chk({tag, "_w_en"}, Coef_w_en, 0);
    chk({tag, "_num"}, Coef_num, 0);
    chk({tag, "_val"}, Coef_Val, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_c_ready"}, c_ready, 0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got no finish expected end of test");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int a;
    logic [7:0] v;
    rst = 1'b1; s_data = '0; s_valid = 1'b0;
    c_start = 1'b0; c_data = '0; c_valid = 1'b0;
`ifdef FEED_PAD_EN
    s_last = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // four back-to-back samples form two pairs
    push(8'd1, a);
    push(8'd2, a);
    pq.push_back('{8'd1, 8'd2, a + 1});
    push(8'd3, a);
    push(8'd4, a);
    pq.push_back('{8'd3, 8'd4, a + 1});
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // full back-to-back coefficient load, then flush window
    start_load();
    @(negedge clk);
    chk("busy_load", busy, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) coef(i, i + 1);
    c_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("busy_flush", busy, (i < 5) ? 1 : 0);
      if (i == 0) chk("c_ready_flush", c_ready, 0);
    end
    @(posedge clk);
    #1;

    // fill the FIFO while the filter side sits in LOAD
    start_load();
    v = 8'd11;
    s_data  = v;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s_ready_fill", s_ready, (i < 4) ? 1 : 0);
      @(posedge clk);
      #1;
      if (i < 4) v = v + 8'd1;
      s_data = v;
    end
    for (int i = 0; i < 10; i++) coef(i, 21 + i);
    c_valid = 1'b0;
    wait_idle();
    chk("s_ready_run0", s_ready, 0);
    pq.push_back('{8'd11, 8'd12, cyc + 1});
    pq.push_back('{8'd13, 8'd14, cyc + 2});
    pq.push_back('{8'd15, 8'd16, cyc + 4});
    @(negedge clk);
    chk("s_ready_run1", s_ready, 1);
    @(posedge clk);
    #1;
    s_data = 8'd16;
    @(negedge clk);
    chk("s_ready_run2", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // stalled load with an ignored c_start in the gap
    start_load();
    for (int i = 0; i < 5; i++) coef(i, 41 + i);
    c_valid = 1'b0;
    @(posedge clk);
    #1;
    c_start = 1'b1;
    @(posedge clk);
    #1;
    c_start = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 5; i < 10; i++) coef(i, 41 + i);
    c_valid = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;

    // reset mid-load empties the FIFO and clears the index
    push(8'd70, a);
    s_valid = 1'b0;
    start_load();
    for (int i = 0; i < 6; i++) coef(i, 61 + i);
    c_data  = 8'd67;
    c_valid = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset("midreset");
    c_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'd71, a);
    push(8'd72, a);
    pq.push_back('{8'd71, 8'd72, a + 1});
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start_load();
    for (int i = 0; i < 10; i++) coef(i, 81 + i);
    c_valid = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;

    // trailing odd sample
    push(8'd7, a);
    push(8'd8, a);
    pq.push_back('{8'd7, 8'd8, a + 1});
`ifdef FEED_PAD_EN
    s_last = 1'b1;
    push(8'd9, a);
    s_last = 1'b0;
    pq.push_back('{8'd9, 8'd0, a + 1});
`else
    push(8'd9, a);
`endif
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    chk("pair_queue_drained", pq.size(), 0);
    chk("coef_queue_drained", cq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
